// File: rtl/div_radix2_axis_if.sv
// Operand and result channels of the radix-2 divider.
// The slave view belongs to the divider; the master view belongs to the ALU side.
interface div_radix2_axis_if;
  logic        s_axis_divisor_tvalid;
  logic        s_axis_divisor_tready;
  logic [31:0] s_axis_divisor_tdata;
  logic        s_axis_dividend_tvalid;
  logic        s_axis_dividend_tready;
  logic [31:0] s_axis_dividend_tdata;
  logic        m_axis_dout_tvalid;
  logic [63:0] m_axis_dout_tdata;

  modport slave (
    input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output s_axis_divisor_tready, s_axis_dividend_tready,
    output m_axis_dout_tvalid, m_axis_dout_tdata
  );

  modport master (
    output s_axis_divisor_tvalid, s_axis_divisor_tdata,
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  s_axis_divisor_tready, s_axis_dividend_tready,
    input  m_axis_dout_tvalid, m_axis_dout_tdata
  );
endinterface

// File: rtl/div_radix2_axis.sv
// Iterative 32-bit radix-2 restoring divider, result {quotient, remainder}.
//
// state | meaning
// IDLE  | both operand channels ready
// WAIT  | one operand captured, waiting for the other
// BUSY  | 32 restoring iterations, one quotient bit per edge
// DONE  | result strobe cycle, nothing accepted
module div_radix2_axis #(
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  div_radix2_axis_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, BUSY, DONE} state_t;

  state_t      state;
  logic [31:0] dvd_hold, dvs_hold;
  logic [31:0] rem, quo, dvs_mag;
  logic [5:0]  cnt;
  logic        dvd_neg, dvs_neg;

  logic        xfer_dvd, xfer_dvs;
  logic [31:0] dvd_in, dvs_in;
  logic        dvd_in_neg, dvs_in_neg;
  logic [32:0] rem_sh, diff;
  logic        borrow;
  logic [31:0] rem_nxt, quo_nxt, quo_fix, rem_fix;

  // Transfer qualifiers and operand selection: a channel transferring now wins over the held copy
  always_comb begin
    xfer_dvd   = bus.s_axis_dividend_tvalid & bus.s_axis_dividend_tready;
    xfer_dvs   = bus.s_axis_divisor_tvalid & bus.s_axis_divisor_tready;
    dvd_in     = xfer_dvd ? bus.s_axis_dividend_tdata : dvd_hold;
    dvs_in     = xfer_dvs ? bus.s_axis_divisor_tdata : dvs_hold;
    dvd_in_neg = SIGNED && dvd_in[31];
    dvs_in_neg = SIGNED && dvs_in[31];
  end

  // One restoring step plus the sign fix-up applied to the final step's result
  always_comb begin
    rem_sh  = {rem, quo[31]};
    diff    = rem_sh - {1'b0, dvs_mag};
    // A set top bit of the shifted remainder means it already exceeds any 32-bit divisor
    borrow  = diff[32] & ~rem_sh[32];
    rem_nxt = borrow ? rem_sh[31:0] : diff[31:0];
    quo_nxt = {quo[30:0], ~borrow};
    quo_fix = (dvd_neg ^ dvs_neg) ? -quo_nxt : quo_nxt;
    rem_fix = dvd_neg ? -rem_nxt : rem_nxt;
  end

  // Handshake FSM, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                      <= IDLE;
      bus.s_axis_dividend_tready <= 1'b0;
      bus.s_axis_divisor_tready  <= 1'b0;
      bus.m_axis_dout_tvalid     <= 1'b0;
      bus.m_axis_dout_tdata      <= '0;
      dvd_hold                   <= '0;
      dvs_hold                   <= '0;
      rem                        <= '0;
      quo                        <= '0;
      dvs_mag                    <= '0;
      cnt                        <= '0;
      dvd_neg                    <= 1'b0;
      dvs_neg                    <= 1'b0;
    end else begin
      bus.m_axis_dout_tvalid <= 1'b0;
      if (xfer_dvd) dvd_hold <= bus.s_axis_dividend_tdata;
      if (xfer_dvs) dvs_hold <= bus.s_axis_divisor_tdata;

      unique case (state)
        IDLE, WAIT: begin
          if (state == IDLE) begin
            bus.s_axis_dividend_tready <= 1'b1;
            bus.s_axis_divisor_tready  <= 1'b1;
          end
          if ((xfer_dvd || state == WAIT) && (xfer_dvs || state == WAIT) &&
              (xfer_dvd || xfer_dvs)) begin
            // Second operand has arrived: load magnitudes and start iterating
            bus.s_axis_dividend_tready <= 1'b0;
            bus.s_axis_divisor_tready  <= 1'b0;
            dvd_neg <= dvd_in_neg;
            dvs_neg <= dvs_in_neg;
            quo     <= dvd_in_neg ? -dvd_in : dvd_in;
            dvs_mag <= dvs_in_neg ? -dvs_in : dvs_in;
            rem     <= '0;
            cnt     <= 6'd31;
            state   <= BUSY;
          end else if (xfer_dvd) begin
            bus.s_axis_dividend_tready <= 1'b0;
            state                      <= WAIT;
          end else if (xfer_dvs) begin
            bus.s_axis_divisor_tready <= 1'b0;
            state                     <= WAIT;
          end
        end
        BUSY: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            bus.m_axis_dout_tdata  <= {quo_fix, rem_fix};
            bus.m_axis_dout_tvalid <= 1'b1;
            state                  <= DONE;
          end
        end
        DONE: begin
          bus.s_axis_dividend_tready <= 1'b1;
          bus.s_axis_divisor_tready  <= 1'b1;
          state                      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2_axis.sv
// Scoreboard bench for div_radix2_axis: one unsigned (index 0) and one signed (index 1) instance.
module tb_div_radix2_axis;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        resetn;
  int          cyc;
  int          tests;
  int          fails;

  logic        dvd_v [2];
  logic        dvs_v [2];
  logic [31:0] dvd_d [2];
  logic [31:0] dvs_d [2];
  logic        dvd_r [2];
  logic        dvs_r [2];
  logic        out_v [2];
  logic [63:0] out_d [2];
  bit          prev_v [2];
  exp_t        sbq [2][$];

  div_radix2_axis_if if_u ();
  div_radix2_axis_if if_s ();

  div_radix2_axis #(.SIGNED(1'b0)) u_div_u (.clk(clk), .resetn(resetn), .bus(if_u));
  div_radix2_axis #(.SIGNED(1'b1)) u_div_s (.clk(clk), .resetn(resetn), .bus(if_s));

  assign if_u.s_axis_dividend_tvalid = dvd_v[0];
  assign if_u.s_axis_dividend_tdata  = dvd_d[0];
  assign if_u.s_axis_divisor_tvalid  = dvs_v[0];
  assign if_u.s_axis_divisor_tdata   = dvs_d[0];
  assign if_s.s_axis_dividend_tvalid = dvd_v[1];
  assign if_s.s_axis_dividend_tdata  = dvd_d[1];
  assign if_s.s_axis_divisor_tvalid  = dvs_v[1];
  assign if_s.s_axis_divisor_tdata   = dvs_d[1];
  assign dvd_r[0] = if_u.s_axis_dividend_tready;
  assign dvs_r[0] = if_u.s_axis_divisor_tready;
  assign out_v[0] = if_u.m_axis_dout_tvalid;
  assign out_d[0] = if_u.m_axis_dout_tdata;
  assign dvd_r[1] = if_s.s_axis_dividend_tready;
  assign dvs_r[1] = if_s.s_axis_divisor_tready;
  assign out_v[1] = if_s.m_axis_dout_tvalid;
  assign out_d[1] = if_s.m_axis_dout_tdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain wide arithmetic with truncating / and %
  function automatic logic [63:0] model(input int m, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (m == 1) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end
    if (sb == 0) begin
      // Raw quotient magnitude is all ones; a negative dividend negates it to 1
      q = (m == 1 && sa < 0) ? 64'd1 : 64'h0000_0000_FFFF_FFFF;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {q[31:0], r[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one divide; dividend leads divisor by 'lead' cycles. Returns the accept edge number.
  task automatic do_div(input int m, input logic [31:0] a, input logic [31:0] b,
                        input int lead, input bit push, output int acc);
    bit   got_a, got_b, xa, xb;
    int   k;
    exp_t e;
    got_a = 0;
    got_b = 0;
    k     = 0;
    acc   = -1;
    dvd_v[m] = 1'b1;
    dvd_d[m] = a;
    if (lead == 0) begin
      dvs_v[m] = 1'b1;
      dvs_d[m] = b;
    end
    while (!(got_a && got_b) && k < 300) begin
      @(negedge clk);
      xa = dvd_v[m] && dvd_r[m] && resetn;
      xb = dvs_v[m] && dvs_r[m] && resetn;
      got_a = got_a | xa;
      got_b = got_b | xb;
      if (got_a && got_b) acc = cyc + 1;
      @(posedge clk);
      #1;
      k++;
      if (xa) begin
        dvd_v[m] = 1'b0;
        dvd_d[m] = $urandom;
      end
      if (xb) begin
        dvs_v[m] = 1'b0;
        dvs_d[m] = $urandom;
      end
      if (lead > 0 && k == lead) begin
        dvs_v[m] = 1'b1;
        dvs_d[m] = b;
      end
    end
    if (!(got_a && got_b)) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout m=%0d: got no accept, expected accept within 300 cycles", m);
      dvd_v[m] = 1'b0;
      dvs_v[m] = 1'b0;
    end else if (push) begin
      e.data = model(m, a, b);
      e.cyc  = acc + 32;
      sbq[m].push_back(e);
    end
  endtask

  task automatic run_random(input int m);
    int          acc, prev;
    logic [31:0] a, b;
    int          sel;
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      a   = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2, 3, 4: b = $urandom_range(1, 255);
        5:       b = a;
        default: b = $urandom;
      endcase
      do_div(m, a, b, 0, 1'b1, acc);
      if (i > 0) chk($sformatf("b2b_gap_m%0d", m), 64'(acc - prev), 64'd34);
      prev = acc;
    end
  endtask

  // Monitor: pop and compare on every result strobe, including its cycle and width
  always @(negedge clk) begin
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      if (out_v[m] === 1'b1) begin
        if (sbq[m].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result m=%0d: got %h, expected no strobe", m, out_d[m]);
        end else begin
          e = sbq[m].pop_front();
          chk($sformatf("result_m%0d", m), out_d[m], e.data);
          chk($sformatf("latency_m%0d", m), 64'(cyc), 64'(e.cyc));
        end
        chk($sformatf("strobe_len_m%0d", m), 64'(prev_v[m]), 64'd0);
      end
      prev_v[m] = (out_v[m] === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of run, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int n;
    cyc    = 0;
    tests  = 0;
    fails  = 0;
    resetn = 1'b0;
    for (int m = 0; m < 2; m++) begin
      dvd_v[m] = 1'b0;
      dvs_v[m] = 1'b0;
      dvd_d[m] = '0;
      dvs_d[m] = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 64'({dvd_r[0], dvs_r[0], dvd_r[1], dvs_r[1]}), 64'd0);
    chk("rst_tvalid", 64'({out_v[0], out_v[1]}), 64'd0);
    chk("rst_tdata_u", out_d[0], 64'd0);
    chk("rst_tdata_s", out_d[1], 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("tready_before_first_edge", 64'({dvd_r[0], dvs_r[0]}), 64'd0);
    @(negedge clk);
    chk("tready_after_release", 64'({dvd_r[0], dvs_r[0], dvd_r[1], dvs_r[1]}), 64'hF);
    @(posedge clk);
    #1;

    // Unsigned basic, with tready profile across the busy window
    do_div(0, 32'd100, 32'd7, 0, 1'b1, acc);
    n = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if ({dvd_r[0], dvs_r[0]} !== 2'b00) n++;
    end
    chk("tready_low_while_busy", 64'(n), 64'd0);
    @(negedge clk);
    chk("tready_back_after_strobe", 64'({dvd_r[0], dvs_r[0]}), 64'd3);
    @(posedge clk);
    #1;

    // Signed sign handling and corner operands
    do_div(1, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, acc);
    do_div(1, 32'd7, 32'hFFFF_FFFE, 0, 1'b1, acc);
    do_div(1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, 1'b1, acc);
    do_div(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, acc);
    do_div(0, 32'h1234_5678, 32'h0, 0, 1'b1, acc);
    do_div(0, 32'hFFFF_FFFF, 32'd1, 0, 1'b1, acc);
    repeat (40) @(posedge clk);
    #1;

    // Staggered: dividend leads divisor by 3 cycles
    fork
      do_div(0, 32'd50, 32'd5, 3, 1'b1, acc);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("stagger_tready", 64'({dvd_r[0], dvs_r[0]}), 64'b01);
      end
    join
    repeat (40) @(posedge clk);
    #1;

    // Reset in the middle of a signed divide: the in-flight result must vanish
    do_div(1, 32'd100, 32'd7, 0, 1'b0, acc);
    repeat (10) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("midrst_tready_low", 64'({dvd_r[1], dvs_r[1]}), 64'd0);
    chk("midrst_tvalid_low", 64'(out_v[1]), 64'd0);
    @(negedge clk);
    chk("midrst_tready_back", 64'({dvd_r[1], dvs_r[1]}), 64'd3);
    repeat (40) @(posedge clk);
    #1;
    do_div(1, 32'd9, 32'd4, 0, 1'b1, acc);
    repeat (40) @(posedge clk);
    #1;

    // Back-to-back random in both modes, tvalids held high throughout
    fork
      run_random(0);
      run_random(1);
    join

    n = 0;
    while ((sbq[0].size() != 0 || sbq[1].size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_u", 64'(sbq[0].size()), 64'd0);
    chk("drain_s", 64'(sbq[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
